// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared defaults and read-port array types for the scoreboarded register file
package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_AW     = $clog2(DEF_NREGS);

  // Packed per-port arrays for the default configuration: [port][bit]
  typedef logic [DEF_NUM_RD-1:0][DEF_AW-1:0]     rd_addr_arr_t;
  typedef logic [DEF_NUM_RD-1:0][DEF_DATA_W-1:0] rd_data_arr_t;

endpackage

// File: rtl/rf_byte_merge.sv
// rtl/rf_byte_merge.sv - byte-enable merge of new data over an existing register value
module rf_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   new_data,
  output logic [DATA_W-1:0]   merged
);

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte
    assign merged[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with byte-enable writes, optional bypass and a pending-producer scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [DATA_W/8-1:0]            wr_be,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           iss_en,
  input  logic [AW-1:0]                  iss_addr,
  input  logic                           flush,
  output logic                           any_busy
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

  // One merge serves both the store and every bypassing read port
  rf_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_data (regs_q[wr_addr]),
    .be       (wr_be),
    .new_data (wr_data),
    .merged   (wr_merged)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_merged;
  end

  // Issue is applied last so a same-edge issue beats both the write clear and flush
  always_comb begin
    pend_d = flush ? '0 : pend_q;
    if (wr_en)  pend_d[wr_addr]  = 1'b0;
    if (iss_ok) pend_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit;
    logic iss_hit;
    logic is_zero;

    assign hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr[p]);
    assign iss_hit = iss_en && (iss_addr == rd_addr[p]);
    assign is_zero = (ZERO_REG != 0) && (rd_addr[p] == '0);

    // Gating on reset keeps the bypass path from leaking wr_data while held in reset
    assign rd_data[p] = (!reset || is_zero) ? '0
                      : (hit ? wr_merged : regs_q[rd_addr[p]]);
    assign rd_busy[p] = reset && !is_zero && pend_q[rd_addr[p]] && !(hit && !iss_hit);
  end

  assign any_busy = |pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb, bypass and non-bypass instances side by side
module tb_reg_file_sb;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0][4:0] rd_addr;
  logic [3:0][31:0] rd_data_b, rd_data_nb;
  logic [3:0]      rd_busy_b, rd_busy_nb;
  logic            any_busy_b, any_busy_nb;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            iss_en;
  logic [4:0]      iss_addr;
  logic            flush;

  int checks = 0;
  int errors = 0;

  int          q_dut  [$];
  int          q_kind [$];
  int          q_port [$];
  logic [31:0] q_exp  [$];
  string       q_name [$];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .NREGS(32), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .any_busy(any_busy_b)
  );

  reg_file_sb #(.DATA_W(32), .NREGS(32), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .any_busy(any_busy_nb)
  );

  // kind 0 = rd_data, 1 = rd_busy, 2 = any_busy; dut 0 = bypass, 1 = no bypass
  task automatic push(input int d, input int k, input int p, input logic [31:0] v, input string n);
    q_dut.push_back(d); q_kind.push_back(k); q_port.push_back(p);
    q_exp.push_back(v); q_name.push_back(n);
  endtask

  task automatic exp_data(input int p, input logic [31:0] vb, input logic [31:0] vnb, input string n);
    push(0, 0, p, vb, {n, "_data_b"});
    push(1, 0, p, vnb, {n, "_data_nb"});
  endtask

  task automatic exp_busy(input int p, input logic vb, input logic vnb, input string n);
    push(0, 1, p, {31'd0, vb}, {n, "_busy_b"});
    push(1, 1, p, {31'd0, vnb}, {n, "_busy_nb"});
  endtask

  task automatic exp_any(input logic v, input string n);
    push(0, 2, 0, {31'd0, v}, {n, "_any_b"});
    push(1, 2, 0, {31'd0, v}, {n, "_any_nb"});
  endtask

  function automatic logic [31:0] actual(input int d, input int k, input int p);
    if (k == 0) return (d == 0) ? rd_data_b[p] : rd_data_nb[p];
    if (k == 1) return {31'd0, (d == 0) ? rd_busy_b[p] : rd_busy_nb[p]};
    return {31'd0, (d == 0) ? any_busy_b : any_busy_nb};
  endfunction

  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      automatic int          d = q_dut.pop_front();
      automatic int          k = q_kind.pop_front();
      automatic int          p = q_port.pop_front();
      automatic logic [31:0] e = q_exp.pop_front();
      automatic string       n = q_name.pop_front();
      automatic logic [31:0] a = actual(d, k, p);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL timeout: stimulus did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wr_be = 4'hF; wr_data = '0; wr_addr = '0; iss_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a);
    for (int i = 0; i < 4; i++) rd_addr[i] = a;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic do_iss(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wr_be = 4'hF; wr_data = '0; wr_addr = '0; iss_addr = '0;
    set_rd(5'd5);

    // Held in reset with a write aimed at the read address
    @(posedge clk); #1;
    do_wr(5'd5, 4'hF, 32'hCAFE0001);
    exp_data(0, 32'h0, 32'h0, "inreset");
    exp_busy(0, 1'b0, 1'b0, "inreset");
    exp_any(1'b0, "inreset");
    @(posedge clk); #1;
    reset = 1'b1;
    wr_en = 1'b0;

    // Write r5 and issue r6, then reset between edges
    next_cycle();
    set_rd(5'd5);
    do_wr(5'd5, 4'hF, 32'hDEADBEEF);
    do_iss(5'd6);
    exp_data(0, 32'hDEADBEEF, 32'h0, "r5_wr");
    next_cycle();
    exp_data(1, 32'hDEADBEEF, 32'hDEADBEEF, "r5_hold");
    exp_any(1'b1, "r6_pend");
    next_cycle();
    reset = 1'b0;
    do_wr(5'd5, 4'hF, 32'h12345678);
    do_iss(5'd5);
    #1;
    checks++;
    if (rd_data_b[0] !== 32'h0 || rd_data_nb[0] !== 32'h0 ||
        rd_busy_b[0] !== 1'b0 || rd_busy_nb[0] !== 1'b0 ||
        any_busy_b !== 1'b0 || any_busy_nb !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data_b %h data_nb %h busy_b %b busy_nb %b any_b %b any_nb %b",
               rd_data_b[0], rd_data_nb[0], rd_busy_b[0], rd_busy_nb[0], any_busy_b, any_busy_nb);
    end
    exp_data(0, 32'h0, 32'h0, "r5_async_rst");
    exp_any(1'b0, "async_rst");
    next_cycle();
    reset = 1'b1;
    exp_data(2, 32'h0, 32'h0, "r5_after_rst");
    exp_busy(2, 1'b0, 1'b0, "r5_after_rst");

    // Byte-enable write
    next_cycle();
    do_wr(5'd3, 4'hF, 32'h11223344);
    next_cycle();
    set_rd(5'd3);
    do_wr(5'd3, 4'b0101, 32'hAABBCCDD);
    exp_data(0, 32'h11BB33DD, 32'h11223344, "r3_be");
    next_cycle();
    exp_data(3, 32'h11BB33DD, 32'h11BB33DD, "r3_be_hold");

    // Zero register
    next_cycle();
    set_rd(5'd0);
    do_wr(5'd0, 4'hF, 32'hFFFFFFFF);
    do_iss(5'd0);
    for (int p = 0; p < 4; p++) begin
      exp_data(p, 32'h0, 32'h0, "r0_wr");
      exp_busy(p, 1'b0, 1'b0, "r0_wr");
    end
    next_cycle();
    exp_data(1, 32'h0, 32'h0, "r0_hold");
    exp_busy(1, 1'b0, 1'b0, "r0_hold");
    exp_any(1'b0, "r0_hold");

    // Scoreboard set and clear by write
    next_cycle();
    set_rd(5'd7);
    do_iss(5'd7);
    exp_busy(0, 1'b0, 1'b0, "r7_iss");
    next_cycle();
    exp_busy(0, 1'b1, 1'b1, "r7_pend");
    exp_any(1'b1, "r7_pend");
    next_cycle();
    do_wr(5'd7, 4'hF, 32'h5);
    exp_busy(0, 1'b0, 1'b1, "r7_wr");
    exp_data(0, 32'h5, 32'h0, "r7_wr");
    next_cycle();
    exp_busy(0, 1'b0, 1'b0, "r7_done");
    exp_data(0, 32'h5, 32'h5, "r7_done");
    exp_any(1'b0, "r7_done");

    // Issue and write collide on r9
    next_cycle();
    rd_addr[0] = 5'd9; rd_addr[1] = 5'd4;
    do_iss(5'd9);
    do_wr(5'd9, 4'hF, 32'h99);
    exp_busy(0, 1'b0, 1'b0, "r9_coll");
    next_cycle();
    exp_busy(0, 1'b1, 1'b1, "r9_pend");
    exp_data(0, 32'h99, 32'h99, "r9_data");
    exp_any(1'b1, "r9_pend");

    // Flush with same-edge issue and write to r4
    next_cycle();
    flush = 1'b1;
    do_iss(5'd4);
    do_wr(5'd4, 4'hF, 32'h12345678);
    exp_busy(0, 1'b1, 1'b1, "r9_preflush");
    next_cycle();
    exp_busy(0, 1'b0, 1'b0, "r9_flushed");
    exp_busy(1, 1'b1, 1'b1, "r4_pend");
    exp_data(1, 32'h12345678, 32'h12345678, "r4_data");
    exp_any(1'b1, "r4_pend");

    // All-zero byte enables still clear pending
    next_cycle();
    do_wr(5'd4, 4'h0, 32'hFFFFFFFF);
    exp_busy(1, 1'b0, 1'b1, "r4_be0");
    exp_data(1, 32'h12345678, 32'h12345678, "r4_be0");
    next_cycle();
    exp_busy(1, 1'b0, 1'b0, "r4_be0_done");
    exp_data(1, 32'h12345678, 32'h12345678, "r4_be0_done");
    exp_any(1'b0, "r4_be0_done");

    // Four ports reading r12 during a write
    next_cycle();
    do_wr(5'd12, 4'hF, 32'h0C0C0C0C);
    next_cycle();
    set_rd(5'd12);
    do_wr(5'd12, 4'hF, 32'h0BADF00D);
    for (int p = 0; p < 4; p++) exp_data(p, 32'h0BADF00D, 32'h0C0C0C0C, "r12_mp");
    next_cycle();
    for (int p = 0; p < 4; p++) exp_data(p, 32'h0BADF00D, 32'h0BADF00D, "r12_mp_hold");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
